// File: rtl/riscv_cpu_pkg.sv
// Shared RV32I opcode/funct3 defines (riscv_defs) plus the decode struct and ALU/branch helpers.
// The defines are global macros so that benches can build instructions as {fields, `OPCODE}.
`ifndef RISCV_DEFS
`define RISCV_DEFS
`define LUI     7'b0110111
`define AUIPC   7'b0010111
`define JAL     7'b1101111
`define JALR    7'b1100111
`define OP_IMM  7'b0010011
`define OP      7'b0110011
`define BRANCH  7'b1100011
`define F3_ADD  3'b000
`define F3_SLL  3'b001
`define F3_SLT  3'b010
`define F3_SLTU 3'b011
`define F3_XOR  3'b100
`define F3_SR   3'b101
`define F3_OR   3'b110
`define F3_AND  3'b111
`define F3_BEQ  3'b000
`define F3_BNE  3'b001
`define F3_BLT  3'b100
`define F3_BGE  3'b101
`define F3_BLTU 3'b110
`define F3_BGEU 3'b111
`endif

package riscv_cpu_pkg;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    // alt selects SUB for funct3=ADD and arithmetic shift for funct3=SR
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            `F3_ADD:  r = alt ? (a - b) : (a + b);
            `F3_SLL:  r = a << b[4:0];
            `F3_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            `F3_SLTU: r = {31'd0, a < b};
            `F3_XOR:  r = a ^ b;
            `F3_SR: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            `F3_OR:   r = a | b;
            default:  r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        logic t;
        case (f3)
            `F3_BEQ:  t = (a == b);
            `F3_BNE:  t = (a != b);
            `F3_BLT:  t = ($signed(a) < $signed(b));
            `F3_BGE:  t = ($signed(a) >= $signed(b));
            `F3_BLTU: t = (a < b);
            `F3_BGEU: t = (a >= b);
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/riscv_prog_mem.sv
// Word-addressed instruction ROM with combinational read; contents are loaded from outside.
module riscv_prog_mem #(
    parameter int IMEM_WORDS = 1024,
    parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       data
);

    logic [31:0] mem [0:IMEM_WORDS-1] = '{default: 32'h0};

    assign data = mem[addr];

endmodule

// File: rtl/riscv_cpu.sv
// Single-cycle RV32I-subset core with internal ROM, 32x32 register file and GPIO mirror.
// Optional macro RISCV_BRANCH_EN enables the BRANCH opcode; otherwise it executes as a NOP.
module riscv_cpu
    import riscv_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int GPIO_REG   = 1,
    parameter int GPIO_LSB   = 12
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] gpio
);

    localparam int          ADDR_W  = $clog2(IMEM_WORDS);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);

    logic [31:0] pc;
    logic [31:0] regs [0:31];
    instr_t      instr;

    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_u, imm_j;
    logic [31:0] pc_plus4, pc_next, rd_val;
    logic        rd_we;

    riscv_prog_mem #(
        .IMEM_WORDS(IMEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) prog (
        .addr(pc[ADDR_W+1:2]),
        .data(instr)
    );

    assign rs1_val  = (instr.rs1 == 5'd0) ? 32'd0 : regs[instr.rs1];
    assign rs2_val  = (instr.rs2 == 5'd0) ? 32'd0 : regs[instr.rs2];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_u    = {instr[31:12], 12'd0};
    assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

`ifdef RISCV_BRANCH_EN
    logic [31:0] imm_b;
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
`endif

    always_comb begin
        rd_we   = 1'b0;
        rd_val  = 32'd0;
        pc_next = pc_plus4;
        case (instr.opcode)
            `LUI: begin
                rd_we  = 1'b1;
                rd_val = imm_u;
            end
            `AUIPC: begin
                rd_we  = 1'b1;
                rd_val = pc + imm_u;
            end
            `JAL: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                pc_next = pc + imm_j;
            end
            `JALR: begin
                rd_we   = 1'b1;
                rd_val  = pc_plus4;
                pc_next = (rs1_val + imm_i) & ~32'd1;
            end
            `OP_IMM: begin
                // imm bit 30 only means "arithmetic" for shifts; ADDI never subtracts
                rd_we  = 1'b1;
                rd_val = alu(instr.funct3, (instr.funct3 == `F3_SR) && instr.funct7[5],
                             rs1_val, imm_i);
            end
            `OP: begin
                rd_we  = 1'b1;
                rd_val = alu(instr.funct3, instr.funct7[5], rs1_val, rs2_val);
            end
`ifdef RISCV_BRANCH_EN
            `BRANCH: begin
                if (branch_taken(instr.funct3, rs1_val, rs2_val)) pc_next = pc + imm_b;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= 32'd0;
            gpio <= 8'd0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else begin
            pc <= pc_next & PC_MASK;
            if (rd_we && instr.rd != 5'd0) begin
                regs[instr.rd] <= rd_val;
                if (instr.rd == 5'(GPIO_REG)) gpio <= rd_val[GPIO_LSB +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_cpu.sv
// Scoreboard bench for riscv_cpu: an ISA-level model predicts pc, gpio and registers each cycle.
`ifndef LUI
`define LUI     7'b0110111
`endif
`ifndef AUIPC
`define AUIPC   7'b0010111
`endif
`ifndef JAL
`define JAL     7'b1101111
`endif
`ifndef JALR
`define JALR    7'b1100111
`endif
`ifndef OP_IMM
`define OP_IMM  7'b0010011
`endif
`ifndef OP
`define OP      7'b0110011
`endif
`ifndef BRANCH
`define BRANCH  7'b1100011
`endif

module tb_riscv_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gpio;

    riscv_cpu #(.IMEM_WORDS(1024), .GPIO_REG(1), .GPIO_LSB(12)) dut (
        .clk (clk),
        .rst (rst),
        .gpio(gpio)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_pc;
        logic [31:0] pc;
        bit          chk_gpio;
        logic [7:0]  gpio;
        int          ridx;
        logic [31:0] rval;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] m_mem [0:1023];
    logic [31:0] m_x   [0:31];
    logic [31:0] m_pc;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, `JAL};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], `BRANCH};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] slt_s(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] calc(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] fill;
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return slt_s(a, b);
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                fill = (alt && a[31]) ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'd0;
                return (a >> b[4:0]) | fill;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return slt_s(a, b) == 32'd1;
            3'd5: return slt_s(a, b) == 32'd0;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, ii, iu, ij, ib, res, npc;
        logic [2:0]  f3;
        int          rd;
        bit          wr;
        ins = m_mem[(m_pc >> 2) & 32'd1023];
        f3  = ins[14:12];
        rd  = int'(ins[11:7]);
        a   = m_x[ins[19:15]];
        b   = m_x[ins[24:20]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        iu  = ins & 32'hFFFF_F000;
        ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        wr  = 1'b0;
        res = 32'd0;
        npc = m_pc + 32'd4;
        case (ins[6:0])
            `LUI:    begin wr = 1'b1; res = iu; end
            `AUIPC:  begin wr = 1'b1; res = m_pc + iu; end
            `JAL:    begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + ij; end
            `JALR:   begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE; end
            `OP_IMM: begin wr = 1'b1; res = calc(f3, (f3 == 3'd5) && ins[30], a, ii); end
            `OP:     begin wr = 1'b1; res = calc(f3, ins[30], a, b); end
            `BRANCH: begin
`ifdef RISCV_BRANCH_EN
                if (taken(f3, a, b)) npc = m_pc + ib;
`endif
            end
            default: ;
        endcase
        if (wr && rd != 0) m_x[rd] = res;
        m_pc = npc & 32'hFFF;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input string name, input bit cp, input logic [31:0] pcv,
                            input bit cg, input logic [7:0] gv, input int r, input logic [31:0] rv);
        exp_t e;
        e.name = name; e.chk_pc = cp; e.pc = pcv; e.chk_gpio = cg; e.gpio = gv;
        e.ridx = r; e.rval = rv;
        sb.push_back(e);
    endtask

    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else     model_step();
        r = cyc % 32;
        cyc++;
        push_exp("model", 1'b1, m_pc, 1'b1, m_x[1][19:12], r, m_x[r]);
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        m_mem[idx] = w;
        dut.prog.mem[idx] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) load(i, 32'd0);
    endtask

    task automatic start_prog();
        rst = 1'b1;
        tick();
        clear_mem();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          k;
        rd  = ($urandom_range(0, 3) == 0) ? 5'd1 : 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        k   = int'($urandom_range(0, 11));
        case (k)
            0: return enc_u(20'($urandom), rd, `LUI);
            1: return enc_u(20'($urandom), rd, `AUIPC);
            2, 3, 4: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, `OP_IMM);
            end
            5, 6: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd, `OP);
            7: return enc_j(21'((int'($urandom_range(0, 16)) - 8) * 4), rd);
            8: return enc_i(12'($urandom_range(0, 64)), rs1, 3'd0, rd, `JALR);
            9: return enc_b(13'((int'($urandom_range(0, 16)) - 8) * 4), rs2, rs1, f3);
            10: return 32'd0;
            default: return {25'($urandom), 7'b0000011};
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.chk_pc) begin
                total++;
                if (dut.pc !== cur.pc) begin
                    bad++;
                    $display("FAIL %s pc: got %h want %h (t=%0t)", cur.name, dut.pc, cur.pc, $time);
                end
            end
            if (cur.chk_gpio) begin
                total++;
                if (gpio !== cur.gpio) begin
                    bad++;
                    $display("FAIL %s gpio: got %h want %h (t=%0t)", cur.name, gpio, cur.gpio, $time);
                end
            end
            if (cur.ridx >= 0) begin
                total++;
                if (dut.regs[cur.ridx] !== cur.rval) begin
                    bad++;
                    $display("FAIL %s x%0d: got %h want %h (t=%0t)", cur.name, cur.ridx,
                             dut.regs[cur.ridx], cur.rval, $time);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        clear_mem();
        tick();
        tick();
        push_exp("reset_state", 1'b1, 32'd0, 1'b1, 8'h00, 1, 32'd0);
        rst = 1'b0;

        // empty memory: sequential fetch and wrap
        repeat (1023) tick();
        push_exp("pc_last_word", 1'b1, 32'd4092, 1'b0, 8'h00, 5, 32'd0);
        tick();
        push_exp("pc_wrap", 1'b1, 32'd0, 1'b1, 8'h00, 31, 32'd0);

        // lui/jalr loop with mid-loop reset
        start_prog();
        load(0, enc_u(20'h0001F, 5'd1, `LUI));
        load(1, enc_u(20'h000F1, 5'd2, `LUI));
        load(31, enc_i(12'd0, 5'd0, 3'd0, 5'd0, `JALR));
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 1) push_exp("lui_x1", 1'b0, 32'd0, 1'b1, 8'h1F, 1, 32'h0001_F000);
            if (k == 2) push_exp("lui_x2", 1'b0, 32'd0, 1'b0, 8'h00, 2, 32'h000F_1000);
            if (k % 32 == 0) push_exp("loop_period", 1'b1, 32'd0, 1'b1, 8'h1F, -1, 32'd0);
        end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        push_exp("mid_reset", 1'b1, 32'd0, 1'b1, 8'h00, 1, 32'd0);
        rst = 1'b0;
        tick();
        push_exp("rerun_x1", 1'b1, 32'd4, 1'b1, 8'h1F, 1, 32'h0001_F000);
        repeat (40) tick();

        // arithmetic wrap-around
        start_prog();
        load(0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, `OP_IMM));
        load(1, enc_i(12'd1, 5'd1, 3'd0, 5'd3, `OP_IMM));
        load(2, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd4, `OP));
        tick();
        rst = 1'b0;
        repeat (3) tick();
        push_exp("addi_neg", 1'b0, 32'd0, 1'b1, 8'hFF, 1, 32'hFFFF_FFFF);
        push_exp("addi_wrap", 1'b0, 32'd0, 1'b0, 8'h00, 3, 32'd0);
        push_exp("sub_neg", 1'b1, 32'd12, 1'b0, 8'h00, 4, 32'd1);
        repeat (5) tick();

        // jal / jalr with odd target
        start_prog();
        load(0, enc_j(21'd8, 5'd5));
        load(1, enc_i(12'd77, 5'd0, 3'd0, 5'd7, `OP_IMM));
        load(2, enc_i(12'd3, 5'd5, 3'd0, 5'd6, `JALR));
        tick();
        rst = 1'b0;
        tick();
        push_exp("jal", 1'b1, 32'd8, 1'b0, 8'h00, 5, 32'd4);
        tick();
        push_exp("jalr", 1'b1, 32'd6, 1'b0, 8'h00, 6, 32'd12);
        tick();
        push_exp("jalr_target", 1'b1, 32'd10, 1'b0, 8'h00, 7, 32'd77);
        repeat (10) tick();

        // branch (or NOP when branches are disabled)
        start_prog();
        load(0, enc_i(12'd5, 5'd0, 3'd0, 5'd1, `OP_IMM));
        load(1, enc_b(13'h1FFC, 5'd1, 5'd1, 3'd0));
        tick();
        rst = 1'b0;
        tick();
        tick();
`ifdef RISCV_BRANCH_EN
        push_exp("beq_taken", 1'b1, 32'd0, 1'b0, 8'h00, 1, 32'd5);
`else
        push_exp("beq_nop", 1'b1, 32'd8, 1'b0, 8'h00, 1, 32'd5);
`endif
        repeat (10) tick();

        // randomized programs, each with a reset in the middle
        for (int round = 0; round < 4; round++) begin
            start_prog();
            for (int i = 0; i < 1024; i++) load(i, rand_instr());
            tick();
            rst = 1'b0;
            repeat (150) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat (150) tick();
        end

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
